spy_path_delay_monitor: RTL and testbench

Launch/capture controller that sits directly around the spy-instrumented combinational path. It drives the path's primary input with alternating rising/falling transitions and samples the path's output a programmable number of clock cycles after each launch. It counts late or incorrect captures separately for rising and falling launches, so a delay added by the inserted payload gate shows up as an error count at a given capture distance.

---
 rtl/spy_path_delay_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_spy_path_delay_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_path_delay_monitor.sv
// spy_path_delay_monitor
// Launch/capture controller wrapped around a spy-instrumented combinational
// path. It toggles launch_out once per trial, samples path_in CAPTURE_DLY
// edges after the launch edge and counts wrong captures separately for
// rising and falling launches.
// Optional feature: define SPY_MON_FIRSTERR_EN to build the first_err
// register (index of the first mismatching trial); otherwise first_err is 0.
// FSM state is visible on dbg_state (IDLE=0, SETTLE=1, LAUNCH=2, WAIT=3,
// EVAL=4, DONE=5).
module spy_path_delay_monitor #(
    parameter int CNT_W       = 16,
    parameter int TRIALS      = 1024,
    parameter int SETTLE_CYC  = 4,
    parameter int CAPTURE_DLY = 1,
    parameter bit INVERT      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    // Control handshake: start and abort are level-sampled single-cycle
    // commands with no ready/acknowledge. start is accepted only in IDLE
    // when abort is low; abort wins over every other transition.
    input  logic             start,
    input  logic             abort,
    output logic             launch_out,
    input  logic             path_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] err_rise,
    output logic [CNT_W-1:0] err_fall,
    output logic [CNT_W-1:0] first_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_EVAL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // One shared phase counter times both SETTLE and WAIT.
    localparam int PH_MAX = (SETTLE_CYC > CAPTURE_DLY) ? SETTLE_CYC : CAPTURE_DLY;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]  WAIT_LAST   = PH_W'(CAPTURE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TRIALS_C    = CNT_W'(TRIALS);

    state_t            state_q, state_d;
    logic              launch_q, launch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cap_q, cap_d;
    logic              dir_rise_q, dir_rise_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  trial_q, trial_d;
    logic [CNT_W-1:0]  err_rise_q, err_rise_d;
    logic [CNT_W-1:0]  err_fall_q, err_fall_d;
    logic              mismatch;
`ifdef SPY_MON_FIRSTERR_EN
    logic [CNT_W-1:0]  first_err_q, first_err_d;
`endif

    // The captured sample is wrong when it differs from the level the path
    // should show for the current launch level.
    assign mismatch = cap_q ^ (launch_q ^ INVERT);

    // Next-state and next-counter computation for the whole controller.
    always_comb begin
        state_d    = state_q;
        launch_d   = launch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cap_d      = cap_q;
        dir_rise_d = dir_rise_q;
        phase_d    = phase_q;
        trial_d    = trial_q;
        err_rise_d = err_rise_q;
        err_fall_d = err_fall_q;
`ifdef SPY_MON_FIRSTERR_EN
        first_err_d = first_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // launch_out keeps its last level while idle.
                if (start && !abort) begin
                    state_d    = S_SETTLE;
                    busy_d     = 1'b1;
                    phase_d    = '0;
                    trial_d    = '0;
                    err_rise_d = '0;
                    err_fall_d = '0;
`ifdef SPY_MON_FIRSTERR_EN
                    // All-ones means "no mismatch yet"; no legal index reaches it.
                    first_err_d = CNT_MAX;
`endif
                end
            end
            S_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = S_LAUNCH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_LAUNCH: begin
                // This edge is the launch edge L.
                launch_d = ~launch_q;
                state_d  = S_WAIT;
                phase_d  = '0;
            end
            S_WAIT: begin
                if (phase_q == WAIT_LAST) begin
                    // Edge L+CAPTURE_DLY: sample the raw path output.
                    cap_d      = path_in;
                    dir_rise_d = launch_q;
                    state_d    = S_EVAL;
                    phase_d    = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (mismatch) begin
                    if (dir_rise_q) begin
                        if (err_rise_q != CNT_MAX) err_rise_d = err_rise_q + 1'b1;
                    end else begin
                        if (err_fall_q != CNT_MAX) err_fall_d = err_fall_q + 1'b1;
                    end
`ifdef SPY_MON_FIRSTERR_EN
                    if (first_err_q == CNT_MAX) first_err_d = trial_q;
`endif
                end
                trial_d = trial_q + 1'b1;
                if (trial_d == TRIALS_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_SETTLE;
                    phase_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort freezes counters and the launch level and skips the done pulse.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            launch_d   = launch_q;
            phase_d    = '0;
            cap_d      = cap_q;
            dir_rise_d = dir_rise_q;
            trial_d    = trial_q;
            err_rise_d = err_rise_q;
            err_fall_d = err_fall_q;
`ifdef SPY_MON_FIRSTERR_EN
            first_err_d = first_err_q;
`endif
        end
    end

    // All controller state, with asynchronous return to the reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            launch_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cap_q      <= 1'b0;
            dir_rise_q <= 1'b0;
            phase_q    <= '0;
            trial_q    <= '0;
            err_rise_q <= '0;
            err_fall_q <= '0;
`ifdef SPY_MON_FIRSTERR_EN
            first_err_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            launch_q   <= launch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cap_q      <= cap_d;
            dir_rise_q <= dir_rise_d;
            phase_q    <= phase_d;
            trial_q    <= trial_d;
            err_rise_q <= err_rise_d;
            err_fall_q <= err_fall_d;
`ifdef SPY_MON_FIRSTERR_EN
            first_err_q <= first_err_d;
`endif
        end
    end

    assign launch_out = launch_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trial_cnt  = trial_q;
    assign err_rise   = err_rise_q;
    assign err_fall   = err_fall_q;
    assign dbg_state  = state_q;
`ifdef SPY_MON_FIRSTERR_EN
    assign first_err  = first_err_q;
`else
    assign first_err  = '0;
`endif

endmodule

// File: tb/tb_spy_path_delay_monitor.sv
// Bench for spy_path_delay_monitor: two instances (INVERT=0 and INVERT=1)
// share control inputs; each drives its own delay-line path model whose
// rising/falling delays and polarity are selectable per run.
module tb_spy_path_delay_monitor;
    localparam int CNT_W  = 16;
    localparam int TRIALS = 8;
    localparam int SETTLE = 4;
    localparam int DLY    = 2;
    localparam int PERIOD = SETTLE + 1 + DLY + 1;
`ifdef SPY_MON_FIRSTERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic launch0, launch1, path0, path1, busy0, busy1, done0, done1;
    logic [CNT_W-1:0] tc0, tc1, er0, er1, ef0, ef1, fe0, fe1;
    logic [2:0] dbg0, dbg1;

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    // path model controls
    int   dr_sel = 1;
    int   df_sel = 1;
    logic pinv_sel = 1'b0;
    logic [2:0] hist0 = '0;
    logic [2:0] hist1 = '0;

    // model state
    logic lv = 1'b0;
    int   last_tc = 0;

    always #5 clk = ~clk;

    spy_path_delay_monitor #(.CNT_W(CNT_W), .TRIALS(TRIALS), .SETTLE_CYC(SETTLE),
                             .CAPTURE_DLY(DLY), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .launch_out(launch0), .path_in(path0), .busy(busy0), .done(done0),
        .trial_cnt(tc0), .err_rise(er0), .err_fall(ef0), .first_err(fe0),
        .dbg_state(dbg0));

    spy_path_delay_monitor #(.CNT_W(CNT_W), .TRIALS(TRIALS), .SETTLE_CYC(SETTLE),
                             .CAPTURE_DLY(DLY), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .launch_out(launch1), .path_in(path1), .busy(busy1), .done(done1),
        .trial_cnt(tc1), .err_rise(er1), .err_fall(ef1), .first_err(fe1),
        .dbg_state(dbg1));

    // Path: a rising launch reaches the output after dr_sel flops, a falling
    // one after df_sel flops, optionally inverted.
    always @(posedge clk) begin
        hist0 <= {hist0[1:0], launch0};
        hist1 <= {hist1[1:0], launch1};
    end
    always_comb begin
        path0 = pinv_sel ^ (launch0 ? hist0[2'(dr_sel - 1)] : hist0[2'(df_sel - 1)]);
        path1 = pinv_sel ^ (launch1 ? hist1[2'(dr_sel - 1)] : hist1[2'(df_sel - 1)]);
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fe_exp(input logic [15:0] v);
        return FE_ON ? v : 16'h0;
    endfunction

    // Reference: per trial, the new level alternates starting opposite lv0;
    // a capture is correct only if that direction's delay is <= DLY-1.
    function automatic void model(input bit inv_dut, input logic lv0, input int n_eval,
                                  input int dr, input int df, input bit pinv,
                                  output logic [15:0] er, output logic [15:0] ef,
                                  output logic [15:0] fe);
        logic n, cap;
        int dly;
        er = 0; ef = 0; fe = 16'hFFFF;
        for (int k = 0; k < n_eval; k++) begin
            n   = lv0 ^ logic'((k + 1) % 2);
            dly = n ? dr : df;
            cap = ((dly <= DLY - 1) ? n : ~n) ^ pinv;
            if (cap != (n ^ inv_dut)) begin
                if (n) er++; else ef++;
                if (fe == 16'hFFFF) fe = 16'(k);
            end
        end
    endfunction

    // One run: start, optional extra start while busy, optional abort at
    // edge E0+a (a=0: run to done), then compare everything.
    task automatic do_run(input string tag, input int a, input int extra_at,
                          input int exp_tc, input logic exp_lv,
                          input logic [15:0] r0, input logic [15:0] f0, input logic [15:0] x0,
                          input logic [15:0] r1, input logic [15:0] f1, input logic [15:0] x1);
        int n;
        int d0, d1;
        d0 = done_cnt0;
        d1 = done_cnt1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_start"}, {30'd0, busy1, busy0}, 32'd3);
        if (a == 0) begin
            n = 0;
            while (done0 !== 1'b1 && n < 200) begin
                if (extra_at > 0 && n == extra_at) start = 1'b1;
                tick();
                start = 1'b0;
                n++;
            end
            check({tag, " latency"}, n + 1, 1 + TRIALS * PERIOD);
            check({tag, " done1"}, {31'd0, done1}, 32'd1);
            tick();
            check({tag, " done_pulse_width"}, {31'd0, done0}, 32'd0);
            check({tag, " done_count"}, done_cnt0 - d0 + done_cnt1 - d1, 2);
        end else begin
            repeat (a - 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check({tag, " busy_after_abort"}, {30'd0, busy1, busy0}, 32'd0);
            repeat (3) tick();
            check({tag, " no_done"}, done_cnt0 - d0 + done_cnt1 - d1, 0);
        end
        check({tag, " trial_cnt0"}, tc0, exp_tc);
        check({tag, " trial_cnt1"}, tc1, exp_tc);
        check({tag, " launch_lvl"}, {30'd0, launch1, launch0}, {30'd0, exp_lv, exp_lv});
        check({tag, " err_rise0"}, er0, r0);
        check({tag, " err_fall0"}, ef0, f0);
        check({tag, " first_err0"}, fe0, fe_exp(x0));
        check({tag, " err_rise1"}, er1, r1);
        check({tag, " err_fall1"}, ef1, f1);
        check({tag, " first_err1"}, fe1, fe_exp(x1));
        last_tc = exp_tc;
    endtask

    task automatic run_model(input string tag, input int a, input int extra_at,
                             input int dr, input int df, input bit pinv);
        int n_eval, n_tog;
        logic lv_new;
        logic [15:0] r0, f0, x0, r1, f1, x1;
        dr_sel = dr; df_sel = df; pinv_sel = pinv;
        n_eval = 0; n_tog = 0;
        for (int k = 0; k < TRIALS; k++) begin
            if (a == 0 || (k + 1) * PERIOD < a) n_eval++;
            if (a == 0 || k * PERIOD + SETTLE + 1 < a) n_tog++;
        end
        model(1'b0, lv, n_eval, dr, df, pinv, r0, f0, x0);
        model(1'b1, lv, n_eval, dr, df, pinv, r1, f1, x1);
        lv_new = lv ^ logic'(n_tog % 2);
        do_run(tag, a, extra_at, n_eval, lv_new, r0, f0, x0, r1, f1, x1);
        lv = lv_new;
    endtask

    typedef struct {
        int          dr;
        int          df;
        logic        pinv;
        logic [15:0] r0, f0, x0, r1, f1, x1;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{1, 1, 1'b0, 16'd0, 16'd0, 16'hFFFF, 16'd4, 16'd4, 16'd0};
        tbl[1] = '{2, 2, 1'b0, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'hFFFF};
        tbl[2] = '{1, 1, 1'b1, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'hFFFF};
        tbl[3] = '{1, 3, 1'b0, 16'd0, 16'd4, 16'd1, 16'd4, 16'd0, 16'd0};

        // clock/reset
        repeat (3) tick();
        check("reset outputs0", {launch0, busy0, done0, tc0, er0, ef0, fe0[12:0]}, 32'd0);
        check("reset outputs1", {launch1, busy1, done1, tc1, er1, ef1, fe1[12:0]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // directed table (level starts at 0, full runs keep it at 0)
        for (int i = 0; i < 4; i++) begin
            dr_sel = tbl[i].dr; df_sel = tbl[i].df; pinv_sel = tbl[i].pinv;
            repeat (3) tick();
            do_run($sformatf("vec%0d", i), 0, 0, TRIALS, 1'b0,
                   tbl[i].r0, tbl[i].f0, tbl[i].x0, tbl[i].r1, tbl[i].f1, tbl[i].x1);
        end

        // abort in WAIT of the third trial
        run_model("abort_t3", 2 * PERIOD + SETTLE + 2, 0, 2, 2, 1'b0);
        check("abort_t3 trial_cnt_const", tc0, 32'd2);

        // start and abort together in IDLE: no run
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (2) tick();
        check("start_abort_idle busy", {31'd0, busy0}, 32'd0);
        check("start_abort_idle trial_cnt", tc0, last_tc);

        // start while busy is ignored; first trial falls from level 1
        run_model("start_busy", 0, 20, 1, 3, 1'b0);

        // asynchronous reset in WAIT of trial 5
        dr_sel = 1; df_sel = 1; pinv_sel = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 * PERIOD + SETTLE + 1) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset outputs0", {launch0, busy0, done0, tc0, er0, ef0, fe0[12:0]}, 32'd0);
        check("midrun_reset outputs1", {launch1, busy1, done1, tc1, er1, ef1, fe1[12:0]}, 32'd0);
        lv = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        run_model("after_reset", 0, 0, 1, 1, 1'b0);

        // randomized runs against the reference model
        for (int i = 0; i < 14; i++) begin
            int a;
            a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, TRIALS * PERIOD)) : 0;
            repeat ($urandom_range(0, 5)) tick();
            run_model($sformatf("rnd%0d", i), a, 0, int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
